ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Controller downstream of the PS/2 byte receiver. Sequences the raw scan-code byte stream (set 2) into discrete key events.
- Handles the E0 extended prefix, the F0 break prefix, the E1 pause sequence and receiver status bytes.
- Tracks held state of the six navigation keys that drive Mandelbrot pan/zoom.
- Buffers events in a small FIFO so the view-control logic can consume them at its own pace.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- TIMEOUT_US, 2000, maximum gap between a prefix byte and its follow-up byte before the sequence is abandoned.
- FIFO_DEPTH, 4, event FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- code_new  in  1  one-cycle strobe; code is valid this cycle.
- code  in  8  received scan-code byte.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event when evt_valid and evt_ready are both 1.
- evt_code  out  8  head event scan code, prefixes stripped.
- evt_ext  out  1  head event was E0-prefixed.
- evt_break  out  1  head event is a release (1) or a press (0).
- evt_repeat  out  1  head event is a typematic make of a mapped key already held.
- key_held  out  6  held flags: [0] up (E0 75), [1] down (E0 72), [2] left (E0 6B), [3] right (E0 74), [4] zoom-in (KP+ 79), [5] zoom-out (KP- 7B).
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset, asynchronous, effective immediately: state IDLE; FIFO empty; evt_valid=0; evt_code=0; evt_ext, evt_break, evt_repeat = 0; key_held=0; overflow=0; timeout counter 0. A sequence in progress when reset asserts is discarded.
- States: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions occur only on cycles where code_new=1, except the timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, skip counter loaded with 7.
  - 00, FF, AA, FA, EE, FE are ignored; stay in IDLE.
  - Any other byte emits a make {code, ext=0}.
- EXT:
  - F0 -> EXT_BRK.
  - 12 or 59 (fake shifts) are ignored -> IDLE.
  - E0 stays in EXT.
  - E1 -> PAUSE.
  - Any other byte emits an extended make -> IDLE.
- BRK:
  - E0 -> EXT (resync).
  - E1 -> PAUSE.
  - F0 stays in BRK.
  - Any other byte emits a break {code, ext=0} -> IDLE.
- EXT_BRK:
  - 12 or 59 are ignored -> IDLE.
  - E0 -> EXT.
  - E1 -> PAUSE.
  - F0 stays in EXT_BRK.
  - Any other byte emits an extended break -> IDLE.
- PAUSE: each byte decrements the skip counter. The state returns to IDLE on the byte that brings it to 0. No event is emitted.
- Timeout:
  - The counter runs in any non-IDLE state and clears on every code_new.
  - On reaching CLK_FREQ/1_000_000*TIMEOUT_US - 1, the state returns to IDLE with no event.
  - If code_new coincides with the terminal count, the byte is processed in the current state and the timeout is ignored.
- Latency: a byte strobed at cycle N produces its event with evt_valid=1 at N+1 if the FIFO was empty. key_held updates at N+1.
- key_held:
  - A make of a mapped key sets its bit; a break clears it.
  - Updates even when the event is dropped on overflow.
  - Unmapped keys never alter key_held.
- evt_repeat is 1 only for a make of a mapped key whose held bit was already 1 before this event.
- FIFO: show-ahead, registered outputs.
  - Push when full and no pop: event dropped, overflow=1 for that cycle.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: no effect.
  - Outputs are stable while evt_valid=1 and evt_ready=0.

Decomposition:
- Package ps2_kbd_pkg contains:
  - byte constants PFX_EXT=E0, PFX_BRK=F0, PFX_PAUSE=E1, and the ignored status codes;
  - the six navigation key codes and their key_held index constants;
  - the decoder state enum typedef;
  - the packed event struct {code[7:0], ext, brk, rep}.
- One sub-module, ps2_evt_fifo: generic synchronous FIFO of the event struct with FIFO_DEPTH, full/empty flags and asynchronous reset.

Test Plan:
- Bytes 1C then F0 1C -> event {1C, ext0, brk0, rep0} then {1C, ext0, brk1}; key_held stays 0.
- E0 75, E0 75, E0 F0 75 -> three events: rep0, then rep1, then brk1; key_held[0] goes 1, 1, 0.
- Print Screen E0 12 E0 7C then E0 F0 7C E0 F0 12 -> only {7C, ext1, brk0} and {7C, ext1, brk1}; fake shifts produce no events.
- Pause E1 14 77 E1 F0 14 F0 77, then 79 -> exactly one event {79, make}; key_held[4]=1.
- E0 then no byte for the TIMEOUT_US period, then 6B -> {6B, ext0, make}, not extended; key_held[2] stays 0.
- evt_ready=0 and six make bytes -> first four events retained in order, overflow pulses twice; reset mid-sequence (after F0) clears all outputs, and the next byte 1C decodes as a make.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, types and lookup helpers for the PS/2 set-2 key decoder.
// Navigation keys map to fixed key_held bit positions.
package ps2_kbd_pkg;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;

    localparam logic [7:0] ST_ZERO    = 8'h00;
    localparam logic [7:0] ST_ERROR   = 8'hFF;
    localparam logic [7:0] ST_BAT_OK  = 8'hAA;
    localparam logic [7:0] ST_ACK     = 8'hFA;
    localparam logic [7:0] ST_ECHO    = 8'hEE;
    localparam logic [7:0] ST_RESEND  = 8'hFE;

    localparam logic [7:0] FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] FAKE_RSHIFT = 8'h59;

    localparam logic [7:0] KEY_UP     = 8'h75;
    localparam logic [7:0] KEY_DOWN   = 8'h72;
    localparam logic [7:0] KEY_LEFT   = 8'h6B;
    localparam logic [7:0] KEY_RIGHT  = 8'h74;
    localparam logic [7:0] KEY_ZIN    = 8'h79;
    localparam logic [7:0] KEY_ZOUT   = 8'h7B;

    localparam logic [2:0] IDX_UP     = 3'd0;
    localparam logic [2:0] IDX_DOWN   = 3'd1;
    localparam logic [2:0] IDX_LEFT   = 3'd2;
    localparam logic [2:0] IDX_RIGHT  = 3'd3;
    localparam logic [2:0] IDX_ZIN    = 3'd4;
    localparam logic [2:0] IDX_ZOUT   = 3'd5;

    localparam int         NAV_KEYS   = 6;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } dec_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
    } key_evt_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } nav_hit_t;

    function automatic logic is_status(input logic [7:0] b);
        return (b == ST_ZERO) || (b == ST_ERROR) || (b == ST_BAT_OK) ||
               (b == ST_ACK)  || (b == ST_ECHO)  || (b == ST_RESEND);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == FAKE_LSHIFT) || (b == FAKE_RSHIFT);
    endfunction

    // Arrow keys only count when E0-prefixed; keypad +/- only when not.
    function automatic nav_hit_t nav_lookup(input logic [7:0] c, input logic ext);
        nav_hit_t r;
        r = '0;
        if (ext) begin
            case (c)
                KEY_UP:    r = '{hit: 1'b1, idx: IDX_UP};
                KEY_DOWN:  r = '{hit: 1'b1, idx: IDX_DOWN};
                KEY_LEFT:  r = '{hit: 1'b1, idx: IDX_LEFT};
                KEY_RIGHT: r = '{hit: 1'b1, idx: IDX_RIGHT};
                default:   r = '0;
            endcase
        end else begin
            case (c)
                KEY_ZIN:   r = '{hit: 1'b1, idx: IDX_ZIN};
                KEY_ZOUT:  r = '{hit: 1'b1, idx: IDX_ZOUT};
                default:   r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO built as a shift queue so the head comes straight from a flop.
// Slots at or above the fill count are kept zero.
module ps2_evt_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     wr_en_i,
    input  key_evt_t wr_data_i,
    input  logic     rd_en_i,
    output key_evt_t rd_data_o,
    output logic     empty_o,
    output logic     full_o,
    output logic     drop_o
);

    localparam int CW = $clog2(DEPTH + 1);

    key_evt_t        mem_q [DEPTH];
    key_evt_t        mem_d [DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   wr_idx;
    logic            pop, push;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign rd_data_o = mem_q[0];

    always_comb begin
        pop     = rd_en_i & ~empty_o;
        push    = wr_en_i & (~full_o | pop);
        drop_o  = wr_en_i & full_o & ~pop;
        wr_idx  = count_q - CW'(pop);
        mem_d   = mem_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CW'(i)) begin
                    mem_d[i] = wr_data_i;
                end
            end
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns the raw set-2 scan-code byte stream into buffered key events and
// tracks the held state of the six pan/zoom navigation keys.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | no prefix pending
// S_EXT     | E0 seen, waiting for extended code
// S_BRK     | F0 seen, waiting for released code
// S_EXT_BRK | E0 F0 seen, waiting for extended released code
// S_PAUSE   | inside the E1 pause sequence, swallowing bytes
module ps2_key_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int TIMEOUT_US = 2000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_new,
    input  logic [7:0] code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic [5:0] key_held,
    output logic       overflow
);

    localparam int TO_CYCLES = (CLK_FREQ / 1000000) * TIMEOUT_US;
    localparam int TO_W      = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    dec_state_e             state_q, state_d;
    logic [2:0]             skip_q, skip_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [NAV_KEYS-1:0]    held_q, held_d;
    logic                   overflow_q;

    logic                   timeout;
    logic                   emit, emit_ext, emit_brk;
    nav_hit_t               nav;
    key_evt_t               evt_in, evt_head;
    logic                   fifo_empty, fifo_full, fifo_drop;

    assign timeout = ~code_new && (state_q != S_IDLE) && (to_cnt_q == TO_LAST);

    always_comb begin
        if (code_new || state_q == S_IDLE || to_cnt_q == TO_LAST) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        if (code_new) begin
            case (state_q)
                S_IDLE: begin
                    if (code == PFX_EXT) begin
                        state_d = S_EXT;
                    end else if (code == PFX_BRK) begin
                        state_d = S_BRK;
                    end else if (code == PFX_PAUSE) begin
                        state_d = S_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end else if (!is_status(code)) begin
                        emit = 1'b1;
                    end
                end
                S_EXT: begin
                    if (code == PFX_BRK) begin
                        state_d = S_EXT_BRK;
                    end else if (is_fake_shift(code)) begin
                        state_d = S_IDLE;
                    end else if (code == PFX_PAUSE) begin
                        state_d = S_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end else if (code != PFX_EXT) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (code == PFX_EXT) begin
                        state_d = S_EXT;
                    end else if (code == PFX_PAUSE) begin
                        state_d = S_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end else if (code != PFX_BRK) begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if (is_fake_shift(code)) begin
                        state_d = S_IDLE;
                    end else if (code == PFX_EXT) begin
                        state_d = S_EXT;
                    end else if (code == PFX_PAUSE) begin
                        state_d = S_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end else if (code != PFX_BRK) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_brk = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_PAUSE: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q <= 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            state_d = S_IDLE;
        end
    end

    // Held flags follow the decoded byte even if the FIFO drops its event.
    always_comb begin
        nav        = nav_lookup(code, emit_ext);
        held_d     = held_q;
        evt_in     = '0;
        evt_in.code = code;
        evt_in.ext  = emit_ext;
        evt_in.brk  = emit_brk;
        evt_in.rep  = emit & ~emit_brk & nav.hit & held_q[nav.idx];
        if (emit && nav.hit) begin
            held_d[nav.idx] = ~emit_brk;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            skip_q     <= '0;
            to_cnt_q   <= '0;
            held_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            to_cnt_q   <= to_cnt_d;
            held_q     <= held_d;
            overflow_q <= fifo_drop;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (reset),
        .wr_en_i   (emit),
        .wr_data_i (evt_in),
        .rd_en_i   (evt_ready),
        .rd_data_o (evt_head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .drop_o    (fifo_drop)
    );

    assign evt_valid  = ~fifo_empty;
    assign evt_code   = evt_head.code;
    assign evt_ext    = evt_head.ext;
    assign evt_break  = evt_head.brk;
    assign evt_repeat = evt_head.rep;
    assign key_held   = held_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; 1 MHz clock and 20 us timeout give a 20-cycle prefix window.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       code_new;
    logic [7:0] code;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_repeat;
    logic [5:0] key_held;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    ps2_key_decoder #(
        .CLK_FREQ   (1000000),
        .TIMEOUT_US (20),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .code_new   (code_new),
        .code       (code),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .evt_repeat (evt_repeat),
        .key_held   (key_held),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] head();
        return {evt_valid, evt_code, evt_ext, evt_break, evt_repeat};
    endfunction

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        code_new = 1'b1;
        code     = b;
        @(negedge clk);
        code_new = 1'b0;
        code     = 8'h00;
    endtask

    task automatic pop_evt();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; code_new = 1'b0; code = 8'h00; evt_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if ({head(), key_held, overflow} !== 19'd0)
            $display("FAIL reset_outputs got=%h exp=0", {head(), key_held, overflow});
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_make_break();
        send_byte(8'h1C);
        n_total++;
        if (head() !== {1'b1, 8'h1C, 3'b000}) $display("FAIL make_1C got=%h exp=%h", head(), {1'b1, 8'h1C, 3'b000});
        else n_pass++;
        pop_evt();
        send_byte(8'hF0);
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL brk_prefix_no_evt got=%b exp=0", evt_valid);
        else n_pass++;
        send_byte(8'h1C);
        n_total++;
        if (head() !== {1'b1, 8'h1C, 3'b010}) $display("FAIL break_1C got=%h exp=%h", head(), {1'b1, 8'h1C, 3'b010});
        else n_pass++;
        n_total++;
        if (key_held !== 6'b000000) $display("FAIL unmapped_held got=%b exp=000000", key_held);
        else n_pass++;
        pop_evt();
        send_byte(8'hAA);
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL status_ignored got=%b exp=0", evt_valid);
        else n_pass++;
    endtask

    task automatic test_nav_repeat();
        send_byte(8'hE0); send_byte(8'h75);
        n_total++;
        if ({head(), key_held} !== {1'b1, 8'h75, 3'b100, 6'b000001})
            $display("FAIL up_make got=%h exp=%h", {head(), key_held}, {1'b1, 8'h75, 3'b100, 6'b000001});
        else n_pass++;
        pop_evt();
        send_byte(8'hE0); send_byte(8'h75);
        n_total++;
        if ({head(), key_held} !== {1'b1, 8'h75, 3'b101, 6'b000001})
            $display("FAIL up_repeat got=%h exp=%h", {head(), key_held}, {1'b1, 8'h75, 3'b101, 6'b000001});
        else n_pass++;
        pop_evt();
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        n_total++;
        if ({head(), key_held} !== {1'b1, 8'h75, 3'b110, 6'b000000})
            $display("FAIL up_break got=%h exp=%h", {head(), key_held}, {1'b1, 8'h75, 3'b110, 6'b000000});
        else n_pass++;
        pop_evt();
    endtask

    task automatic test_print_screen();
        send_byte(8'hE0); send_byte(8'h12);
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL fake_shift_make got=%b exp=0", evt_valid);
        else n_pass++;
        send_byte(8'hE0); send_byte(8'h7C);
        n_total++;
        if (head() !== {1'b1, 8'h7C, 3'b100}) $display("FAIL prtsc_make got=%h exp=%h", head(), {1'b1, 8'h7C, 3'b100});
        else n_pass++;
        pop_evt();
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h7C);
        n_total++;
        if (head() !== {1'b1, 8'h7C, 3'b110}) $display("FAIL prtsc_break got=%h exp=%h", head(), {1'b1, 8'h7C, 3'b110});
        else n_pass++;
        pop_evt();
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL fake_shift_break got=%b exp=0", evt_valid);
        else n_pass++;
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL pause_silent got=%b exp=0", evt_valid);
        else n_pass++;
        send_byte(8'h79);
        n_total++;
        if ({head(), key_held} !== {1'b1, 8'h79, 3'b000, 6'b010000})
            $display("FAIL after_pause got=%h exp=%h", {head(), key_held}, {1'b1, 8'h79, 3'b000, 6'b010000});
        else n_pass++;
        pop_evt();
        send_byte(8'hF0); send_byte(8'h79);
        n_total++;
        if ({head(), key_held} !== {1'b1, 8'h79, 3'b010, 6'b000000})
            $display("FAIL zin_break got=%h exp=%h", {head(), key_held}, {1'b1, 8'h79, 3'b010, 6'b000000});
        else n_pass++;
        pop_evt();
    endtask

    task automatic test_timeout();
        send_byte(8'hE0);
        repeat (20) @(negedge clk);
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL timeout_no_evt got=%b exp=0", evt_valid);
        else n_pass++;
        send_byte(8'h6B);
        n_total++;
        if ({head(), key_held} !== {1'b1, 8'h6B, 3'b000, 6'b000000})
            $display("FAIL timeout_plain got=%h exp=%h", {head(), key_held}, {1'b1, 8'h6B, 3'b000, 6'b000000});
        else n_pass++;
        pop_evt();
        send_byte(8'hE0);
        repeat (19) @(negedge clk);
        send_byte(8'h74);
        n_total++;
        if ({head(), key_held} !== {1'b1, 8'h74, 3'b100, 6'b001000})
            $display("FAIL terminal_byte got=%h exp=%h", {head(), key_held}, {1'b1, 8'h74, 3'b100, 6'b001000});
        else n_pass++;
        pop_evt();
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        n_total++;
        if (key_held !== 6'b000000) $display("FAIL right_release got=%b exp=000000", key_held);
        else n_pass++;
        pop_evt();
    endtask

    task automatic test_overflow();
        logic [7:0] fill [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
        logic [7:0] rest [3] = '{8'h23, 8'h2B, 8'h4B};
        for (int i = 0; i < 4; i++) begin
            send_byte(fill[i]);
            n_total++;
            if (overflow !== 1'b0) $display("FAIL fill_no_ovf idx=%0d got=%b exp=0", i, overflow);
            else n_pass++;
        end
        send_byte(8'hE0);
        send_byte(8'h75);
        n_total++;
        if ({overflow, key_held} !== {1'b1, 6'b000001})
            $display("FAIL ovf_first got=%h exp=%h", {overflow, key_held}, {1'b1, 6'b000001});
        else n_pass++;
        send_byte(8'h33);
        n_total++;
        if (overflow !== 1'b1) $display("FAIL ovf_second got=%b exp=1", overflow);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({overflow, head()} !== {1'b0, 1'b1, 8'h1C, 3'b000})
            $display("FAIL ovf_end_head got=%h exp=%h", {overflow, head()}, {1'b0, 1'b1, 8'h1C, 3'b000});
        else n_pass++;
        code_new = 1'b1; code = 8'h4B; evt_ready = 1'b1;
        @(negedge clk);
        code_new = 1'b0; code = 8'h00; evt_ready = 1'b0;
        n_total++;
        if ({overflow, head()} !== {1'b0, 1'b1, 8'h1B, 3'b000})
            $display("FAIL full_push_pop got=%h exp=%h", {overflow, head()}, {1'b0, 1'b1, 8'h1B, 3'b000});
        else n_pass++;
        pop_evt();
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (head() !== {1'b1, rest[i], 3'b000})
                $display("FAIL drain idx=%0d got=%h exp=%h", i, head(), {1'b1, rest[i], 3'b000});
            else n_pass++;
            pop_evt();
        end
        pop_evt();
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL pop_empty got=%b exp=0", evt_valid);
        else n_pass++;
        send_byte(8'h1C);
        send_byte(8'hF0);
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({head(), key_held, overflow} !== 19'd0)
            $display("FAIL midseq_reset got=%h exp=0", {head(), key_held, overflow});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'h1C);
        n_total++;
        if (head() !== {1'b1, 8'h1C, 3'b000}) $display("FAIL post_reset_make got=%h exp=%h", head(), {1'b1, 8'h1C, 3'b000});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_nav_repeat();
        test_print_screen();
        test_pause();
        test_timeout();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
